// File: rtl/lcmv_pkg.sv
// rtl/lcmv_pkg.sv - shared LCMV datapath types
// Purpose: enums shared by the LCMV shifters and serializers.
//   shift_dir_t : element order / shift direction (right = element 0 first)
//   ser_state_t : vector serializer control state
package lcmv_pkg;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } shift_dir_t;

   typedef enum logic {
      SER_IDLE,
      SER_SHIFTING
   } ser_state_t;

endpackage

// File: rtl/elem_shift_register.sv
// rtl/elem_shift_register.sv - N-deep bidirectional element shifter with zero fill
// Purpose: holds one vector of elements and shifts it one slot per request.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears all slots)
//   clear           : zero all slots (beats load and shift)
//   load, load_data : capture a full vector, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   shift           : move every element one slot toward the head
//   direction_right : 1 = head is slot 0, 0 = head is slot N_ELEMS-1
//   slot_first      : contents of slot 0
//   slot_last       : contents of slot N_ELEMS-1
module elem_shift_register #(
   parameter int N_ELEMS    = 5,
   parameter int DATA_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load,
   input  logic [N_ELEMS*DATA_WIDTH-1:0] load_data,
   input  logic                          shift,
   input  logic                          direction_right,
   input  logic                          clear,
   output logic [DATA_WIDTH-1:0]         slot_first,
   output logic [DATA_WIDTH-1:0]         slot_last
);

   logic [DATA_WIDTH-1:0] r_slots [N_ELEMS];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int i = 0; i < N_ELEMS; i++) r_slots[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < N_ELEMS; i++) r_slots[i] <= load_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (shift) begin
         if (direction_right) begin
            // head is slot 0: pull everything down, zero enters at the top
            for (int i = 0; i < N_ELEMS-1; i++) r_slots[i] <= r_slots[i+1];
            r_slots[N_ELEMS-1] <= '0;
         end else begin
            // head is the top slot: push everything up, zero enters at slot 0
            for (int i = N_ELEMS-1; i > 0; i--) r_slots[i] <= r_slots[i-1];
            r_slots[0] <= '0;
         end
      end
   end

   assign slot_first = r_slots[0];
   assign slot_last  = r_slots[N_ELEMS-1];

endmodule

// File: rtl/bidir_vector_serializer.sv
// rtl/bidir_vector_serializer.sv - parallel vector in, one element per cycle out
// Purpose: accepts an N_ELEMS vector in one handshake and streams its elements
// in the per-vector direction, with zero-bubble back-to-back reloads.
// Ports:
//   clk, rst                                 : clock, synchronous active-high reset
//   in_valid/in_ready/in_data                : parallel vector input handshake
//   in_direction_right                       : order for the vector being loaded
//   flush                                    : abort current vector, return to idle
//   out_valid/out_ready/out_data             : element output handshake
//   out_last                                 : final element of the vector
//   out_index                                : original index of the current element
module bidir_vector_serializer
   import lcmv_pkg::*;
#(
   parameter  int N_ELEMS    = 5,
   parameter  int DATA_WIDTH = 16,
   localparam int IDX_WIDTH  = $clog2(N_ELEMS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_ELEMS*DATA_WIDTH-1:0] in_data,
   input  logic                          in_direction_right,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_last,
   output logic [IDX_WIDTH-1:0]          out_index
);

   localparam logic [IDX_WIDTH-1:0] LAST_COUNT = IDX_WIDTH'(N_ELEMS - 1);

   ser_state_t           r_state;
   shift_dir_t           r_dir;
   logic [IDX_WIDTH-1:0] r_count;

   logic                  w_out_hs;
   logic                  w_is_last;
   logic                  w_load;
   logic [DATA_WIDTH-1:0] w_slot_first;
   logic [DATA_WIDTH-1:0] w_slot_last;

   assign out_valid = (r_state == SER_SHIFTING);
   assign w_is_last = out_valid && (r_count == LAST_COUNT);
   assign w_out_hs  = out_valid && out_ready;
   // Accepting while the last element leaves keeps the stream bubble-free.
   assign in_ready  = !flush && ((r_state == SER_IDLE) || (w_out_hs && w_is_last));
   assign w_load    = in_valid && in_ready;

   assign out_last  = w_is_last;
   assign out_data  = !out_valid ? '0 :
                      (r_dir == DIR_RIGHT) ? w_slot_first : w_slot_last;
   assign out_index = !out_valid ? '0 :
                      (r_dir == DIR_RIGHT) ? r_count : (LAST_COUNT - r_count);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SER_IDLE;
         r_dir   <= DIR_RIGHT;
         r_count <= '0;
      end else if (flush) begin
         r_state <= SER_IDLE;
         r_count <= '0;
      end else if (w_load) begin
         r_state <= SER_SHIFTING;
         r_dir   <= in_direction_right ? DIR_RIGHT : DIR_LEFT;
         r_count <= '0;
      end else if (w_out_hs) begin
         if (w_is_last) begin
            r_state <= SER_IDLE;
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   // The final element needs no shift: the vector is either reloaded or abandoned.
   elem_shift_register #(
      .N_ELEMS    (N_ELEMS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_elems (
      .clk             (clk),
      .rst             (rst),
      .load            (w_load),
      .load_data       (in_data),
      .shift           (w_out_hs && !w_is_last),
      .direction_right (r_dir == DIR_RIGHT),
      .clear           (flush),
      .slot_first      (w_slot_first),
      .slot_last       (w_slot_last)
   );

endmodule

// File: tb/tb_bidir_vector_serializer.sv
// tb/tb_bidir_vector_serializer.sv - self-checking bench for bidir_vector_serializer
module tb_bidir_vector_serializer;

   localparam int N  = 5;
   localparam int W  = 16;
   localparam int IW = $clog2(N);

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] in_data;
   logic           in_direction_right;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic           out_last;
   logic [IW-1:0]  out_index;

   int checks = 0;
   int errors = 0;

   // expected element stream, front = element currently due on the output
   logic [W-1:0] q_data [$];
   int           q_idx  [$];
   bit           q_last [$];

   always #5 clk = ~clk;

   bidir_vector_serializer #(.N_ELEMS(N), .DATA_WIDTH(W)) dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_data            (in_data),
      .in_direction_right (in_direction_right),
      .flush              (flush),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_data           (out_data),
      .out_last           (out_last),
      .out_index          (out_index)
   );

   function automatic logic [N*W-1:0] seq_vec(input int base);
      logic [N*W-1:0] v;
      for (int k = 0; k < N; k++) v[k*W +: W] = W'(base + k);
      return v;
   endfunction

   function automatic logic [N*W-1:0] rand_vec();
      logic [N*W-1:0] v;
      for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
      return v;
   endfunction

   // Emission order: right sends element 0 first, left sends element N-1 first.
   function automatic void push_vec(input logic [N*W-1:0] v, input bit right);
      for (int j = 0; j < N; j++) begin
         int k;
         k = right ? j : N - 1 - j;
         q_data.push_back(v[k*W +: W]);
         q_idx.push_back(k);
         q_last.push_back(j == N - 1);
      end
   endfunction

   function automatic void pop_exp();
      void'(q_data.pop_front());
      void'(q_idx.pop_front());
      void'(q_last.pop_front());
   endfunction

   function automatic void clear_exp();
      q_data.delete();
      q_idx.delete();
      q_last.delete();
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_direction_right = 1'b1;
      flush = 1'b0; out_ready = 1'b0;
      clear_exp();
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_index !== '0 ||
          out_data !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: got v=%b l=%b i=%0d d=%h rdy=%b, want v=0 l=0 i=0 d=0000 rdy=1",
                  out_valid, out_last, out_index, out_data, in_ready);
      end
      tick();
   endtask

   task automatic test_basic(input bit right);
      clear_exp();
      push_vec(seq_vec(1), right);
      in_valid = 1'b1; in_data = seq_vec(1); in_direction_right = right; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_load_ready dir=%0d: got %b want 1", right, in_ready);
      end
      tick();
      in_valid = 1'b0;
      for (int j = 0; j < N; j++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== q_data[0] ||
             out_index !== IW'(q_idx[0]) || out_last !== q_last[0]) begin
            errors++;
            $display("FAIL basic_elem dir=%0d #%0d: got v=%b d=%h i=%0d l=%b, want v=1 d=%h i=%0d l=%b",
                     right, j, out_valid, out_data, out_index, out_last, q_data[0], q_idx[0], q_last[0]);
         end
         pop_exp();
         tick();
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_end dir=%0d: out_valid got %b want 0", right, out_valid);
      end
      tick();
   endtask

   task automatic test_backpressure();
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [N*W-1:0] v;
      int hs;
      bit done;
      hs = 0; done = 1'b0;
      v = rand_vec();
      clear_exp();
      push_vec(v, 1'b1);
      in_valid = 1'b1; in_data = v; in_direction_right = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      in_direction_right = 1'b0;   // must not affect the vector in flight
      for (int c = 0; c < 40 && !done; c++) begin
         out_ready = pat[c % 4];
         @(negedge clk);
         checks++;
         if (q_data.size() == 0) begin
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL bp_end: out_valid got %b want 0", out_valid);
            end
            done = 1'b1;
         end else begin
            if (out_valid !== 1'b1 || out_data !== q_data[0] ||
                out_index !== IW'(q_idx[0]) || out_last !== q_last[0]) begin
               errors++;
               $display("FAIL bp_elem cyc %0d: got v=%b d=%h i=%0d l=%b, want v=1 d=%h i=%0d l=%b",
                        c, out_valid, out_data, out_index, out_last, q_data[0], q_idx[0], q_last[0]);
            end
            if (out_ready && out_valid) begin
               pop_exp();
               hs++;
            end
         end
         tick();
      end
      checks++;
      if (hs != N || !done) begin
         errors++;
         $display("FAIL bp_handshakes: got %0d (done=%0d) want %0d", hs, done, N);
      end
   endtask

   task automatic test_back_to_back();
      clear_exp();
      push_vec(seq_vec(1), 1'b1);
      push_vec(seq_vec(16'h00A0), 1'b0);
      in_valid = 1'b1; in_data = seq_vec(1); in_direction_right = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first_ready: got %b want 1", in_ready);
      end
      tick();
      in_data = seq_vec(16'h00A0); in_direction_right = 1'b0;
      for (int j = 0; j < 2*N; j++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== q_data[0] || out_index !== IW'(q_idx[0]) ||
             out_last !== q_last[0] || in_ready !== (j % N == N - 1)) begin
            errors++;
            $display("FAIL b2b_elem #%0d: got v=%b d=%h i=%0d l=%b rdy=%b, want v=1 d=%h i=%0d l=%b rdy=%b",
                     j, out_valid, out_data, out_index, out_last, in_ready,
                     q_data[0], q_idx[0], q_last[0], (j % N == N - 1));
         end
         pop_exp();
         tick();
         if (j == N - 1) in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: out_valid got %b want 0", out_valid);
      end
      tick();
   endtask

   task automatic test_flush();
      logic [N*W-1:0] v;
      v = rand_vec();
      in_valid = 1'b1; in_data = v; in_direction_right = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();                       // two elements consumed
      flush = 1'b1;
      in_valid = 1'b1; in_data = seq_vec(16'h0011); in_direction_right = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_cycle: got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
      end
      tick();
      flush = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_after: got v=%b d=%h rdy=%b want v=0 d=0000 rdy=1",
                  out_valid, out_data, in_ready);
      end
      clear_exp();
      push_vec(seq_vec(16'h0011), 1'b1);
      tick();
      in_valid = 1'b0;
      for (int j = 0; j < N; j++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== q_data[0] ||
             out_index !== IW'(q_idx[0]) || out_last !== q_last[0]) begin
            errors++;
            $display("FAIL flush_reload #%0d: got v=%b d=%h i=%0d l=%b, want v=1 d=%h i=%0d l=%b",
                     j, out_valid, out_data, out_index, out_last, q_data[0], q_idx[0], q_last[0]);
         end
         pop_exp();
         tick();
      end
   endtask

   task automatic test_reset_mid_vector();
      in_valid = 1'b1; in_data = rand_vec(); in_direction_right = 1'b0; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_index !== '0 ||
          out_data !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: got v=%b l=%b i=%0d d=%h rdy=%b, want v=0 l=0 i=0 d=0000 rdy=1",
                  out_valid, out_last, out_index, out_data, in_ready);
      end
      tick();
      test_basic(1'b1);
   endtask

   // Random traffic: the model is just the queue of still-owed elements.
   task automatic test_random();
      bit exp_ready;
      bit loaded;
      clear_exp();
      in_valid = 1'b0; flush = 1'b0;
      for (int c = 0; c < 600; c++) begin
         flush     = ($urandom_range(0, 39) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid) begin
            in_valid           = ($urandom_range(0, 2) != 0);
            in_data            = rand_vec();
            in_direction_right = $urandom_range(0, 1);
         end
         @(negedge clk);
         exp_ready = !flush && (q_data.size() == 0 || (out_ready && q_last[0]));
         checks++;
         if (in_ready !== exp_ready || out_valid !== (q_data.size() != 0)) begin
            errors++;
            $display("FAIL rand_ctrl cyc %0d: got rdy=%b v=%b, want rdy=%b v=%b",
                     c, in_ready, out_valid, exp_ready, (q_data.size() != 0));
         end
         if (q_data.size() != 0) begin
            checks++;
            if (out_data !== q_data[0] || out_index !== IW'(q_idx[0]) || out_last !== q_last[0]) begin
               errors++;
               $display("FAIL rand_elem cyc %0d: got d=%h i=%0d l=%b, want d=%h i=%0d l=%b",
                        c, out_data, out_index, out_last, q_data[0], q_idx[0], q_last[0]);
            end
         end
         loaded = in_valid && exp_ready;
         if (flush) begin
            clear_exp();
         end else begin
            if (q_data.size() != 0 && out_ready) pop_exp();
            if (loaded) push_vec(in_data, in_direction_right);
         end
         tick();
         if (loaded) in_valid = 1'b0;
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic(1'b1);
      test_basic(1'b0);
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_reset_mid_vector();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bidir_vector_serializer.md
Name: bidir_vector_serializer

Overview:
- Parallel-in, serial-out counterpart to the team's bidirectional shift register.
- Accepts a vector of N_ELEMS elements in one handshake and emits them one element per cycle on a valid/ready stream.
- Per-vector direction control: right = element 0 first, left = element N_ELEMS-1 first.
- Feeds LCMV systolic-array rows/columns from parallel result buffers.

Parameters:
N_ELEMS, 5, number of elements per vector (>=2)
DATA_WIDTH, 16, bits per element
IDX_WIDTH, $clog2(N_ELEMS), width of out_index (derived localparam, not overridable)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-high reset
in_valid  input  1  parallel vector available
in_ready  output  1  serializer can accept a vector this cycle
in_data  input  N_ELEMS*DATA_WIDTH  element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
in_direction_right  input  1  sampled with in_data; 1 = emit element 0 first, 0 = emit element N_ELEMS-1 first
flush  input  1  abort current vector, return to IDLE
out_valid  output  1  out_data holds a valid element
out_ready  input  1  downstream accepts element
out_data  output  DATA_WIDTH  current element
out_last  output  1  current element is the final one of the vector
out_index  output  IDX_WIDTH  original index k of the current element in in_data

Behaviour:
- The design has one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, element register all zero, count=0, out_valid=0, out_last=0, out_index=0, out_data=0. in_ready=1 after reset.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - SHIFTING: out_valid=1.
- Load: an in_valid&&in_ready handshake at edge t captures in_data, in_direction_right, and count=0; state becomes SHIFTING. First element is visible (out_valid=1) from t+1. Latency is 1 cycle.
- Head element:
  - Right direction: register slot 0. After each output handshake, shift toward slot 0, inserting zero at slot N_ELEMS-1.
  - Left direction: slot N_ELEMS-1. After each output handshake, shift toward slot N_ELEMS-1, inserting zero at slot 0.
- out_data = head slot, combinational from registers. out_data is 0 in IDLE.
- out_index:
  - Right direction: equals count.
  - Left direction: equals N_ELEMS-1-count.
- out_last = out_valid && (count == N_ELEMS-1).
- Output handshake (out_valid&&out_ready):
  - Not last: shift the register and increment count.
  - Last: go to IDLE unless a load occurs in the same cycle.
- Stall: while out_valid && !out_ready, out_data, out_index, out_last, and all state hold.
- Back-to-back: in_ready = (state==IDLE) || (out_valid && out_ready && out_last) — a combinational path from out_ready. A simultaneous last-handshake plus load reloads the register, sets count=0, and stays in SHIFTING. This gives a sustained throughput of N_ELEMS cycles per vector with no bubbles.
- in_direction_right is ignored except on a load cycle. A direction change mid-vector has no effect.
- flush: the next state is IDLE, the register is zeroed, count=0, and out_valid drops at the next edge. in_ready=0 while flush=1, so no load can coincide with flush. An output handshake in the flush cycle still counts as consumed.
- Priority: rst > flush > load > shift.
- Count is never allowed to wrap. Reaching N_ELEMS-1 forces last.

Decomposition:
- Shared package lcmv_pkg:
  - typedef enum logic {DIR_LEFT=1'b0, DIR_RIGHT=1'b1} shift_dir_t, also used by the existing bidirectional shift register.
  - typedef enum logic {SER_IDLE, SER_SHIFTING} ser_state_t.
- Sub-module elem_shift_register: a DATA_WIDTH-wide, N_ELEMS-deep bidirectional element shifter.
  - Ports: clk, rst, load, load_data, shift, direction_right, clear.
  - Zero fill on shift.
  - The top-level module owns the FSM, count, and handshakes.

Test Plan:
- Basic right (N_ELEMS=5, DATA_WIDTH=16):
  - Stimulus: in_data elements {0x0001..0x0005}, direction=1, out_ready=1 constant.
  - Required: from t+1, out_data = 1,2,3,4,5 on consecutive cycles; out_index = 0..4; out_last only with 0x0005; out_valid=0 at t+6.
- Basic left:
  - Stimulus: same vector, direction=0.
  - Required: out_data = 5,4,3,2,1; out_index = 4,3,2,1,0; out_last with 0x0001.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1,… during a right vector.
  - Required: each element held stable across stall cycles; exactly 5 handshakes; no element duplicated or dropped.
- Back-to-back:
  - Stimulus: second vector {0xA0..0xA4}, direction=0, held valid during the first vector.
  - Required: in_ready=1 only in the last-handshake cycle; 0xA4 appears on the very next cycle after 0x0005 with no bubble; 10 elements in 10 cycles.
- Flush:
  - Stimulus: flush asserted after 2 handshakes.
  - Required: out_valid=0 the next cycle, in_ready=1 the following cycle. A new vector {0x11..0x15}, direction=1, then emits 0x11 first with out_index=0 and no stale data.
- Reset mid-vector:
  - Stimulus: rst for 1 cycle during SHIFTING.
  - Required: all outputs equal their reset values the next cycle, and a fresh load behaves as in the basic right scenario.
